// File: rtl/pipe_ctrl.sv
// Stall/flush/bubble sequencing, data-memory handshake and WB->EX forwarding
// for the IF | EX/MEM | WB pipeline. Define PIPE_PERF_CNT_EN for stall/flush counters.
module pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ex_mem_req,
  input  logic       i_ex_mem_wr,
  input  logic       i_ex_br_taken,
  input  logic [4:0] i_ex_rs1,
  input  logic [4:0] i_ex_rs2,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_regwr,
  input  logic       i_dmem_ready,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_pc_en,
  output logic       o_ifex_flush,
  output logic       o_wb_bubble,
  output logic       o_fwd_a,
  output logic       o_fwd_b,
  output logic       o_bus_err,
  output logic       o_busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);

  // state    | meaning
  // S_RUN    | pipeline advancing; zero-wait accesses complete here
  // S_MEM_WAIT | access outstanding, pipeline stalled, wait counter running
  // S_ERR    | memory timed out; pipeline frozen until reset
  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_we;
  logic             w_we_nxt;
  logic             r_bus_err;
  logic             w_bus_err_nxt;

  logic w_req;
  logic w_we;
  logic w_pc_en;
  logic w_flush;
  logic w_bubble;
  logic w_fwd_a;
  logic w_fwd_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_RUN;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_we      <= w_we_nxt;
      r_bus_err <= w_bus_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_we_nxt      = r_we;
    w_bus_err_nxt = r_bus_err;
    w_req         = 1'b0;
    w_we          = 1'b0;
    w_pc_en       = 1'b0;
    w_flush       = 1'b0;
    w_bubble      = 1'b1;
    case (r_state)
      S_RUN: begin
        if (i_ex_mem_req) begin
          // a memory op wins over a coincident branch
          w_req    = 1'b1;
          w_we     = i_ex_mem_wr;
          w_we_nxt = i_ex_mem_wr;
          if (i_dmem_ready) begin
            w_pc_en  = 1'b1;
            w_bubble = 1'b0;
          end else begin
            w_state_nxt = S_MEM_WAIT;
            w_cnt_nxt   = CNT_W'(1);
          end
        end else begin
          w_pc_en  = 1'b1;
          w_bubble = 1'b0;
          w_flush  = i_ex_br_taken;
        end
      end
      S_MEM_WAIT: begin
        w_req = 1'b1;
        w_we  = r_we;
        if (i_dmem_ready) begin
          // a branch held during the stall is flushed on the completion cycle
          w_pc_en     = 1'b1;
          w_bubble    = 1'b0;
          w_flush     = i_ex_br_taken;
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= LP_TIMEOUT) begin
          w_state_nxt   = S_ERR;
          w_bus_err_nxt = 1'b1;
        end else if (r_cnt != LP_CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_fwd_a = i_wb_regwr & (i_wb_rd != 5'd0) & (i_wb_rd == i_ex_rs1);
  assign w_fwd_b = i_wb_regwr & (i_wb_rd != 5'd0) & (i_wb_rd == i_ex_rs2);

  // reset overrides the FSM view so a mid-access reset drops the request at once
  assign o_dmem_req   = ~i_rst & w_req;
  assign o_dmem_we    = ~i_rst & w_we;
  assign o_pc_en      = ~i_rst & w_pc_en;
  assign o_ifex_flush =  i_rst | w_flush;
  assign o_wb_bubble  =  i_rst | w_bubble;
  assign o_fwd_a      = w_fwd_a & ~o_wb_bubble;
  assign o_fwd_b      = w_fwd_b & ~o_wb_bubble;
  assign o_bus_err    = r_bus_err;
  assign o_busy       = ~i_rst & (r_state != S_RUN);

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_en)     r_stall_cnt <= r_stall_cnt + 32'd1;
      if (o_ifex_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: transaction-level stimulus pushes expected
// per-cycle output vectors; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_ex_mem_req = 1'b0;
  logic       i_ex_mem_wr = 1'b0;
  logic       i_ex_br_taken = 1'b0;
  logic [4:0] i_ex_rs1 = '0;
  logic [4:0] i_ex_rs2 = '0;
  logic [4:0] i_wb_rd = '0;
  logic       i_wb_regwr = 1'b0;
  logic       i_dmem_ready = 1'b0;
  logic       o_dmem_req, o_dmem_we, o_pc_en, o_ifex_flush, o_wb_bubble;
  logic       o_fwd_a, o_fwd_b, o_bus_err, o_busy;

  localparam int TIMEOUT = 15;

  pipe_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ex_mem_req(i_ex_mem_req), .i_ex_mem_wr(i_ex_mem_wr),
    .i_ex_br_taken(i_ex_br_taken), .i_ex_rs1(i_ex_rs1), .i_ex_rs2(i_ex_rs2),
    .i_wb_rd(i_wb_rd), .i_wb_regwr(i_wb_regwr), .i_dmem_ready(i_dmem_ready),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_pc_en(o_pc_en),
    .o_ifex_flush(o_ifex_flush), .o_wb_bubble(o_wb_bubble),
    .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_bus_err(o_bus_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [8:0] exp_q[$];
  string      name_q[$];
  int         tests = 0;
  int         fails = 0;
  bit         err_flag = 0;
  bit         rnd_fwd = 1;

  // vector order: {req, we, pc_en, flush, bubble, fwd_a, fwd_b, bus_err, busy}
  always @(negedge i_clk) begin
    if (exp_q.size() != 0) begin
      logic [8:0] e;
      logic [8:0] g;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      g = {o_dmem_req, o_dmem_we, o_pc_en, o_ifex_flush, o_wb_bubble,
           o_fwd_a, o_fwd_b, o_bus_err, o_busy};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL %s @%0t: got {req,we,pc,fl,bub,fa,fb,err,busy}=%b required %b",
                 n, $time, g, e);
      end
    end
  end

  task automatic step(input bit rst, mreq, mwr, br, rdy,
                      input bit e_req, e_we, e_pc, e_fl, e_bub, e_err, e_busy,
                      input string nm);
    bit fa, fb;
    i_rst = rst; i_ex_mem_req = mreq; i_ex_mem_wr = mwr;
    i_ex_br_taken = br; i_dmem_ready = rdy;
    if (rnd_fwd) begin
      i_wb_rd    = 5'($urandom_range(0, 3));
      i_ex_rs1   = 5'($urandom_range(0, 3));
      i_ex_rs2   = 5'($urandom_range(0, 3));
      i_wb_regwr = 1'($urandom_range(0, 1));
    end
    fa = i_wb_regwr && (i_wb_rd != 0) && (i_wb_rd == i_ex_rs1) && !e_bub;
    fb = i_wb_regwr && (i_wb_rd != 0) && (i_wb_rd == i_ex_rs2) && !e_bub;
    exp_q.push_back({e_req, e_we, e_pc, e_fl, e_bub, fa, fb, e_err, e_busy});
    name_q.push_back(nm);
    @(posedge i_clk); #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
           1'($urandom_range(0, 1)),
           0, 0, 0, 1, 1, (i == 0) ? err_flag : 1'b0, 0, "reset");
      err_flag = 0;
    end
  endtask

  task automatic do_idle(input int n, input bit rnd_br);
    for (int i = 0; i < n; i++) begin
      bit br;
      br = rnd_br ? 1'($urandom_range(0, 1)) : 1'b0;
      step(0, 0, 1'($urandom_range(0, 1)), br, 1'($urandom_range(0, 1)),
           0, 0, 1, br, 0, err_flag, 0, "idle");
    end
  endtask

  // access with nw wait cycles: ready on cycle nw, request held nw+1 cycles
  task automatic do_mem(input bit wr, input int nw, input bit br_wait);
    for (int c = 0; c <= nw; c++) begin
      bit last, br;
      last = (c == nw);
      br   = br_wait && (c >= 1);
      step(0, 1, wr, br, last,
           1, wr, last, br && last, !last, err_flag, c >= 1,
           wr ? "store" : "load");
    end
  endtask

  task automatic do_timeout(input bit wr, input int err_cycles);
    for (int c = 0; c <= TIMEOUT; c++)
      step(0, 1, wr, 0, 0, 1, wr, 0, 0, 1, 0, c >= 1, "timeout_wait");
    err_flag = 1;
    for (int c = 0; c < err_cycles; c++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           0, 0, 0, 0, 1, 1, 1, "err_hold");
  endtask

  task automatic do_abort(input bit wr, input int waits);
    for (int c = 0; c <= waits; c++)
      step(0, 1, wr, 0, 0, 1, wr, 0, 0, 1, 0, c >= 1, "abort_wait");
    do_reset(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "after_abort");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    @(posedge i_clk); #1;
    do_reset(2);
    do_idle(3, 0);

    rnd_fwd = 0;
    i_wb_regwr = 1; i_wb_rd = 5; i_ex_rs1 = 5; i_ex_rs2 = 6;
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "fwd_rd5");
    i_wb_rd = 0; i_ex_rs1 = 0; i_ex_rs2 = 0;
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "fwd_rd0");
    i_wb_rd = 7; i_ex_rs1 = 7; i_ex_rs2 = 7;
    do_mem(0, 2, 0);
    rnd_fwd = 1;

    do_mem(0, 0, 0);
    do_idle(1, 0);
    do_mem(1, 3, 0);
    do_idle(1, 0);
    do_mem(0, 2, 1);
    do_idle(2, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, "branch");
    do_idle(1, 0);
    do_mem(1, TIMEOUT, 0);
    do_idle(1, 0);
    do_timeout(1, 4);
    do_reset(2);
    do_idle(1, 0);
    do_abort(0, 3);
    do_idle(1, 0);

    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op < 8)       do_idle($urandom_range(1, 3), 1);
      else if (op < 17) do_mem(1'($urandom_range(0, 1)), $urandom_range(0, 6),
                               1'($urandom_range(0, 1)));
      else if (op < 18) begin
        do_timeout(1'($urandom_range(0, 1)), $urandom_range(1, 3));
        do_reset($urandom_range(1, 2));
      end
      else if (op < 19) do_abort(1'($urandom_range(0, 1)), $urandom_range(0, 5));
      else              do_reset($urandom_range(1, 2));
    end

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge i_clk);
    @(negedge i_clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
